// File: rtl/hub_pkg.sv
// Shared types and default thresholds for the hub port guard.
// Thresholds are in nibbles at the 100M MII strobe rate.
package hub_pkg;

  typedef enum logic [1:0] {
    JAB_IDLE,
    JAB_ACTIVE,
    JAB_JABBER,
    JAB_UNJAB
  } jab_state_e;

  typedef enum logic {
    PART_CONNECTED,
    PART_PARTITIONED
  } part_state_e;

  localparam int DEF_JABBER_NIBBLES    = 10000;
  localparam int DEF_UNJAB_NIBBLES     = 2500;
  localparam int DEF_CC_LIMIT          = 60;
  localparam int DEF_LONG_COL_NIBBLES  = 256;
  localparam int DEF_RECONNECT_NIBBLES = 128;

endpackage

// File: rtl/hub_port_jabber.sv
// Jabber FSM for one hub port: cuts off over-long receive activity and
// re-enables the port after a sustained quiet period.
//
// state      | meaning
// JAB_IDLE   | no reception in progress
// JAB_ACTIVE | reception in progress, length being counted
// JAB_JABBER | cut off, still receiving
// JAB_UNJAB  | cut off, counting quiet nibbles
module hub_port_jabber
  import hub_pkg::*;
#(
  parameter int JABBER_NIBBLES = DEF_JABBER_NIBBLES,
  parameter int UNJAB_NIBBLES  = DEF_UNJAB_NIBBLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic rx_dv,
  output logic pass,
  output logic trunc,
  output logic jabbering_nxt
);

  localparam int LW = $clog2(JABBER_NIBBLES + 1);
  localparam int QW = $clog2(UNJAB_NIBBLES + 1);

  jab_state_e     state_q, state_d;
  logic [LW-1:0]  len_q, len_d, len_inc;
  logic [QW-1:0]  quiet_q, quiet_d, quiet_inc;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    quiet_d   = quiet_q;
    trunc     = 1'b0;
    len_inc   = (state_q == JAB_IDLE) ? LW'(1) : len_q + LW'(1);
    // The quiet nibble that leaves JABBER is the first of the unjab run.
    quiet_inc = (state_q == JAB_JABBER) ? QW'(1) : quiet_q + QW'(1);
    if (ce) begin
      case (state_q)
        JAB_IDLE, JAB_ACTIVE: begin
          if (rx_dv) begin
            len_d = len_inc;
            if (len_inc == LW'(JABBER_NIBBLES)) begin
              trunc   = 1'b1;
              state_d = JAB_JABBER;
            end else begin
              state_d = JAB_ACTIVE;
            end
          end else begin
            state_d = JAB_IDLE;
          end
        end
        JAB_JABBER, JAB_UNJAB: begin
          if (rx_dv) begin
            state_d = JAB_JABBER;
          end else begin
            quiet_d = quiet_inc;
            state_d = (quiet_inc == QW'(UNJAB_NIBBLES)) ? JAB_IDLE : JAB_UNJAB;
          end
        end
        default: state_d = JAB_IDLE;
      endcase
    end
  end

  assign pass          = (state_q == JAB_IDLE) || (state_q == JAB_ACTIVE);
  assign jabbering_nxt = (state_d == JAB_JABBER) || (state_d == JAB_UNJAB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= JAB_IDLE;
      len_q   <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      quiet_q <= quiet_d;
    end
  end

endmodule

// File: rtl/hub_port_guard.sv
// Per-port jabber/partition guard between MII elastic buffer and repeater core.
// Define HUB_PORT_GUARD_COUNTERS_EN to implement the saturating event counters.
module hub_port_guard
  import hub_pkg::*;
#(
  parameter int JABBER_NIBBLES    = DEF_JABBER_NIBBLES,
  parameter int UNJAB_NIBBLES     = DEF_UNJAB_NIBBLES,
  parameter int CC_LIMIT          = DEF_CC_LIMIT,
  parameter int LONG_COL_NIBBLES  = DEF_LONG_COL_NIBBLES,
  parameter int RECONNECT_NIBBLES = DEF_RECONNECT_NIBBLES,
  parameter int COUNTER_WIDTH     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     rx_dv,
  input  logic                     rx_er,
  input  logic [3:0]               rxd,
  input  logic                     jam,
  output logic                     out_dv,
  output logic                     out_er,
  output logic [3:0]               outd,
  output logic                     jabbering,
  output logic                     partitioned,
  output logic [COUNTER_WIDTH-1:0] jabber_count,
  output logic [COUNTER_WIDTH-1:0] partition_count
);

  localparam int RW  = $clog2(RECONNECT_NIBBLES + 1);
  localparam int CLW = $clog2(LONG_COL_NIBBLES + 1);
  localparam int CCW = $clog2(CC_LIMIT + 1);

  logic jab_pass, jab_trunc, jab_nxt;

  hub_port_jabber #(
    .JABBER_NIBBLES (JABBER_NIBBLES),
    .UNJAB_NIBBLES  (UNJAB_NIBBLES)
  ) u_jabber (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .rx_dv         (rx_dv),
    .pass          (jab_pass),
    .trunc         (jab_trunc),
    .jabbering_nxt (jab_nxt)
  );

  part_state_e     part_q, part_d;
  logic [CCW-1:0]  cc_q, cc_d, cc_inc;
  logic [RW-1:0]   rx_len_q, rx_len_d, rx_len_inc;
  logic [CLW-1:0]  col_len_q, col_len_d, col_len_inc;
  logic            col_seen_q, col_seen_d;
  logic            in_rx_q, in_rx_d;
  logic            out_dv_q, out_dv_d, out_er_q, out_er_d;
  logic [3:0]      outd_q, outd_d;
  logic            jabbering_q, jabbering_d, partitioned_q, partitioned_d;
  logic            col_hit, rx_end, open;

  always_comb begin
    part_d        = part_q;
    cc_d          = cc_q;
    rx_len_d      = rx_len_q;
    col_len_d     = col_len_q;
    col_seen_d    = col_seen_q;
    in_rx_d       = in_rx_q;
    out_dv_d      = out_dv_q;
    out_er_d      = out_er_q;
    outd_d        = outd_q;
    jabbering_d   = jabbering_q;
    partitioned_d = partitioned_q;

    col_hit     = rx_dv & jam;
    rx_end      = in_rx_q & ~rx_dv;
    open        = jab_pass && (part_q == PART_CONNECTED);
    cc_inc      = (cc_q == CCW'(CC_LIMIT)) ? cc_q : cc_q + CCW'(1);
    rx_len_inc  = !in_rx_q ? RW'(1) :
                  (rx_len_q == RW'(RECONNECT_NIBBLES)) ? rx_len_q : rx_len_q + RW'(1);
    col_len_inc = !in_rx_q ? CLW'(col_hit) :
                  (col_len_q == CLW'(LONG_COL_NIBBLES)) ? col_len_q : col_len_q + CLW'(col_hit);

    if (ce) begin
      in_rx_d = rx_dv;
      if (rx_dv) begin
        rx_len_d   = rx_len_inc;
        col_len_d  = col_len_inc;
        col_seen_d = (in_rx_q & col_seen_q) | col_hit;
      end

      case (part_q)
        PART_CONNECTED: begin
          if (rx_dv && col_len_inc == CLW'(LONG_COL_NIBBLES)) begin
            part_d = PART_PARTITIONED;
          end else if (rx_end) begin
            if (col_seen_q) begin
              cc_d = cc_inc;
              if (cc_inc == CCW'(CC_LIMIT)) part_d = PART_PARTITIONED;
            end else if (rx_len_q == RW'(RECONNECT_NIBBLES)) begin
              cc_d = '0;
            end
          end
        end
        PART_PARTITIONED: begin
          // Reconnect only between frames so output never resumes mid-frame.
          if (rx_end && !col_seen_q && rx_len_q == RW'(RECONNECT_NIBBLES)) begin
            part_d = PART_CONNECTED;
            cc_d   = '0;
          end
        end
        default: part_d = PART_CONNECTED;
      endcase

      out_dv_d      = open & rx_dv;
      out_er_d      = open & (rx_er | jab_trunc);
      outd_d        = open ? rxd : 4'h0;
      jabbering_d   = jab_nxt;
      partitioned_d = (part_d == PART_PARTITIONED);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      part_q        <= PART_CONNECTED;
      cc_q          <= '0;
      rx_len_q      <= '0;
      col_len_q     <= '0;
      col_seen_q    <= 1'b0;
      in_rx_q       <= 1'b0;
      out_dv_q      <= 1'b0;
      out_er_q      <= 1'b0;
      outd_q        <= 4'h0;
      jabbering_q   <= 1'b0;
      partitioned_q <= 1'b0;
    end else begin
      part_q        <= part_d;
      cc_q          <= cc_d;
      rx_len_q      <= rx_len_d;
      col_len_q     <= col_len_d;
      col_seen_q    <= col_seen_d;
      in_rx_q       <= in_rx_d;
      out_dv_q      <= out_dv_d;
      out_er_q      <= out_er_d;
      outd_q        <= outd_d;
      jabbering_q   <= jabbering_d;
      partitioned_q <= partitioned_d;
    end
  end

  assign out_dv      = out_dv_q;
  assign out_er      = out_er_q;
  assign outd        = outd_q;
  assign jabbering   = jabbering_q;
  assign partitioned = partitioned_q;

`ifdef HUB_PORT_GUARD_COUNTERS_EN
  logic                     jab_evt, part_evt;
  logic [COUNTER_WIDTH-1:0] jab_cnt_q, jab_cnt_d, part_cnt_q, part_cnt_d;

  assign jab_evt  = ce & jab_trunc;
  assign part_evt = ce && (part_q == PART_CONNECTED) && (part_d == PART_PARTITIONED);

  always_comb begin
    jab_cnt_d  = jab_cnt_q;
    part_cnt_d = part_cnt_q;
    if (jab_evt && !(&jab_cnt_q))   jab_cnt_d  = jab_cnt_q + 1'b1;
    if (part_evt && !(&part_cnt_q)) part_cnt_d = part_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jab_cnt_q  <= '0;
      part_cnt_q <= '0;
    end else begin
      jab_cnt_q  <= jab_cnt_d;
      part_cnt_q <= part_cnt_d;
    end
  end

  assign jabber_count    = jab_cnt_q;
  assign partition_count = part_cnt_q;
`else
  assign jabber_count    = '0;
  assign partition_count = '0;
`endif

endmodule
